// File: rtl/adder_pipe.sv
// Pipelined add/sub/accumulate unit with valid/ready flow control on both sides.
// Operands travel through STAGES-1 skid-free holding stages; all arithmetic happens on entry to the output stage.
module adder_pipe #(
  parameter int WIDTH    = 8,
  parameter int SWIDTH   = WIDTH + 1,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic              cin,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SWIDTH-1:0] sm,
  output logic              sm_zero,
  output logic              sm_ovf,
  output logic [SWIDTH-1:0] acc
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam int         PAD      = SWIDTH + 1 - WIDTH;

  logic              out_valid_q;
  logic [SWIDTH-1:0] sm_q;
  logic              zero_q;
  logic              ovf_q;
  logic [SWIDTH-1:0] acc_q;

  logic              ld_last;
  logic              last_vld;
  logic [1:0]        last_mode;
  logic              last_cin;
  logic [WIDTH-1:0]  last_x;
  logic [WIDTH-1:0]  last_y;

  logic [SWIDTH:0]   ext_x;
  logic [SWIDTH:0]   ext_y;
  logic [SWIDTH:0]   ext_cin;
  logic [SWIDTH:0]   ext_acc;
  logic [SWIDTH:0]   r_sum;
  logic [SWIDTH-1:0] res_d;
  logic              ovf_d;
  logic [SWIDTH-1:0] acc_d;

  // Bit SWIDTH of the extended result is carry-out for add and borrow for subtract.
  function automatic logic [SWIDTH-1:0] sat_fn(input logic [SWIDTH:0] r, input logic is_sub);
    if (SATURATE && r[SWIDTH]) return is_sub ? '0 : '1;
    return r[SWIDTH-1:0];
  endfunction

  assign ld_last = ~out_valid_q | out_ready;

  generate
    if (STAGES == 1) begin : g_direct
      assign in_ready  = ld_last;
      assign last_vld  = in_valid;
      assign last_mode = mode;
      assign last_cin  = cin;
      assign last_x    = x;
      assign last_y    = y;
    end else begin : g_pipe
      localparam int M = STAGES - 1;
      logic [M-1:0]     vld_q;
      logic [M-1:0]     ld;
      logic             free;
      logic [1:0]       mode_q [M];
      logic             cin_q  [M];
      logic [WIDTH-1:0] x_q    [M];
      logic [WIDTH-1:0] y_q    [M];

      // A stage may load if it or any stage downstream of it has room.
      always_comb begin
        free = ld_last;
        ld   = '0;
        for (int i = M - 1; i >= 0; i--) begin
          free  = free | ~vld_q[i];
          ld[i] = free;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          if (ld[0]) vld_q[0] <= in_valid;
          for (int i = 1; i < M; i++)
            if (ld[i]) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (ld[0]) begin
          mode_q[0] <= mode;
          cin_q[0]  <= cin;
          x_q[0]    <= x;
          y_q[0]    <= y;
        end
        for (int i = 1; i < M; i++) begin
          if (ld[i]) begin
            mode_q[i] <= mode_q[i-1];
            cin_q[i]  <= cin_q[i-1];
            x_q[i]    <= x_q[i-1];
            y_q[i]    <= y_q[i-1];
          end
        end
      end

      assign in_ready  = ld[0];
      assign last_vld  = vld_q[M-1];
      assign last_mode = mode_q[M-1];
      assign last_cin  = cin_q[M-1];
      assign last_x    = x_q[M-1];
      assign last_y    = y_q[M-1];
    end
  endgenerate

  always_comb begin
    ext_x   = {{PAD{1'b0}}, last_x};
    ext_y   = {{PAD{1'b0}}, last_y};
    ext_cin = {{SWIDTH{1'b0}}, last_cin};
    ext_acc = {1'b0, acc_q};
    r_sum   = '0;
    res_d   = '0;
    ovf_d   = 1'b0;
    acc_d   = acc_q;
    case (last_mode)
      MODE_ADD: begin
        r_sum = ext_x + ext_y + ext_cin;
        ovf_d = r_sum[SWIDTH];
        res_d = sat_fn(r_sum, 1'b0);
      end
      MODE_SUB: begin
        r_sum = ext_x - ext_y - ext_cin;
        ovf_d = r_sum[SWIDTH];
        res_d = sat_fn(r_sum, 1'b1);
      end
      MODE_ACC: begin
        r_sum = ext_acc + ext_x + ext_cin;
        ovf_d = r_sum[SWIDTH];
        res_d = sat_fn(r_sum, 1'b0);
        acc_d = res_d;
      end
      default: acc_d = '0;
    endcase
  end

  // Output stage: doubles as the last pipeline register, so results hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sm_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (ld_last) begin
      out_valid_q <= last_vld;
      if (last_vld) begin
        sm_q   <= res_d;
        zero_q <= (res_d == '0);
        ovf_q  <= ovf_d;
        acc_q  <= acc_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sm        = sm_q;
  assign sm_zero   = zero_q;
  assign sm_ovf    = ovf_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: wrap (STAGES=2), saturating (STAGES=2) and STAGES=1 instances share stimulus.
module tb_adder_pipe;

  localparam logic [1:0] ADD = 2'd0;
  localparam logic [1:0] SUB = 2'd1;
  localparam logic [1:0] ACC = 2'd2;
  localparam logic [1:0] CLR = 2'd3;

  logic       clk, rst_n, in_valid, out_ready, cin;
  logic [1:0] mode;
  logic [7:0] x, y;

  logic       a_in_ready, a_out_valid, a_zero, a_ovf;
  logic [8:0] a_sm, a_acc;
  logic       b_in_ready, b_out_valid, b_zero, b_ovf;
  logic [8:0] b_sm, b_acc;
  logic       c_in_ready, c_out_valid, c_zero, c_ovf;
  logic [8:0] c_sm, c_acc;

  int checks = 0;
  int errors = 0;

  adder_pipe #(.WIDTH(8), .SWIDTH(9), .STAGES(2), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .mode(mode),
    .cin(cin), .x(x), .y(y), .out_valid(a_out_valid), .out_ready(out_ready), .sm(a_sm),
    .sm_zero(a_zero), .sm_ovf(a_ovf), .acc(a_acc));

  adder_pipe #(.WIDTH(8), .SWIDTH(9), .STAGES(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .mode(mode),
    .cin(cin), .x(x), .y(y), .out_valid(b_out_valid), .out_ready(out_ready), .sm(b_sm),
    .sm_zero(b_zero), .sm_ovf(b_ovf), .acc(b_acc));

  adder_pipe #(.WIDTH(8), .SWIDTH(9), .STAGES(1), .SATURATE(1'b0)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready), .mode(mode),
    .cin(cin), .x(x), .y(y), .out_valid(c_out_valid), .out_ready(out_ready), .sm(c_sm),
    .sm_zero(c_zero), .sm_ovf(c_ovf), .acc(c_acc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat for exactly one rising edge; returns at the following falling edge.
  task automatic issue(input logic [1:0] m, input logic c, input logic [7:0] xx, input logic [7:0] yy);
    @(negedge clk);
    in_valid = 1'b1; mode = m; cin = c; x = xx; y = yy;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  int   sent, got;
  logic fire_in, fire_out, stale;
  logic [8:0] obs_sm;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = ADD; cin = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_sm", 32'(a_sm), 32'd0);
    chk("rst_acc", 32'(a_acc), 32'd0);
    chk("rst_flags", 32'({a_zero, a_ovf}), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    rst_n = 1'b1;

    // ADD with maximal operands fits in SWIDTH bits
    issue(ADD, 1'b1, 8'd255, 8'd255);
    #1;
    chk("add_latency_not_yet", 32'(a_out_valid), 32'd0);
    chk("s1_add_valid", 32'(c_out_valid), 32'd1);
    chk("s1_add_sm", 32'(c_sm), 32'd511);
    @(negedge clk); #1;
    chk("add_valid", 32'(a_out_valid), 32'd1);
    chk("add_sm", 32'(a_sm), 32'd511);
    chk("add_ovf_zero", 32'({a_ovf, a_zero}), 32'd0);

    // SUB with borrow, wrapped vs saturated
    issue(SUB, 1'b0, 8'd5, 8'd7);
    #1;
    chk("s1_sub_sm", 32'(c_sm), 32'h1FE);
    @(negedge clk); #1;
    chk("sub_sm", 32'(a_sm), 32'h1FE);
    chk("sub_ovf", 32'(a_ovf), 32'd1);
    chk("sub_zero", 32'(a_zero), 32'd0);
    chk("sat_sub_sm", 32'(b_sm), 32'd0);
    chk("sat_sub_zero_ovf", 32'({b_zero, b_ovf}), 32'd3);

    // CLR then three accumulations of 200
    issue(CLR, 1'b0, 8'd77, 8'd0);
    @(negedge clk); #1;
    chk("clr_sm", 32'(a_sm), 32'd0);
    chk("clr_zero_ovf", 32'({a_zero, a_ovf}), 32'd2);
    chk("clr_acc", 32'(a_acc), 32'd0);
    issue(ACC, 1'b0, 8'd200, 8'd99);
    @(negedge clk); #1;
    chk("acc1_sm", 32'(a_sm), 32'd200);
    chk("sat_acc1_sm", 32'(b_sm), 32'd200);
    issue(ACC, 1'b0, 8'd200, 8'd0);
    @(negedge clk); #1;
    chk("acc2_sm", 32'(a_sm), 32'd400);
    chk("acc2_ovf", 32'(a_ovf), 32'd0);
    issue(ACC, 1'b0, 8'd200, 8'd0);
    @(negedge clk); #1;
    chk("acc3_sm", 32'(a_sm), 32'd88);
    chk("acc3_ovf", 32'(a_ovf), 32'd1);
    chk("acc3_acc", 32'(a_acc), 32'd88);
    chk("sat_acc3_sm", 32'(b_sm), 32'd511);
    chk("sat_acc3_acc", 32'(b_acc), 32'd511);
    chk("sat_acc3_ovf", 32'(b_ovf), 32'd1);
    chk("s1_acc3_acc", 32'(c_acc), 32'd88);
    @(negedge clk); #1;
    chk("acc_valid_drops", 32'(a_out_valid), 32'd0);

    // Stream 6 ADD beats (x=10k, y=k -> 11k) with the consumer stalled for 4 cycles
    @(negedge clk);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = (cyc >= 4);
      if (sent < 6) begin
        in_valid = 1'b1; mode = ADD; cin = 1'b0;
        x = 8'(10 * (sent + 1)); y = 8'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        chk("stall_in_ready_low", 32'(a_in_ready), 32'd0);
        chk("stall_accepted", 32'(sent), 32'd2);
      end
      if (cyc == 3) chk("stall_hold_sm", 32'({a_out_valid, a_sm}), 32'h20B);
      fire_in  = in_valid & a_in_ready;
      fire_out = a_out_valid & out_ready;
      obs_sm   = a_sm;
      @(posedge clk);
      if (fire_in) sent++;
      if (fire_out) begin
        chk("stream_order", 32'(obs_sm), 32'(11 * (got + 1)));
        got++;
      end
      @(negedge clk);
    end
    chk("stream_all_delivered", 32'(got), 32'd6);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset with beats in flight and acc = 123
    issue(CLR, 1'b0, 8'd0, 8'd0);
    issue(ACC, 1'b0, 8'd123, 8'd0);
    @(negedge clk); #1;
    chk("pre_rst_acc", 32'(a_acc), 32'd123);
    out_ready = 1'b0;
    in_valid = 1'b1; mode = ADD; cin = 1'b0; x = 8'd3; y = 8'd4;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_full", 32'({a_out_valid, a_in_ready}), 32'd2);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_async_valid", 32'(a_out_valid), 32'd0);
    chk("rst_async_acc", 32'(a_acc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      stale = stale | a_out_valid | b_out_valid | c_out_valid;
    end
    chk("no_stale_after_rst", 32'(stale), 32'd0);
    issue(ADD, 1'b0, 8'd1, 8'd1);
    @(negedge clk); #1;
    chk("post_rst_add", 32'({a_out_valid, a_sm}), 32'h202);

    // STAGES=1 back-to-back: x=k+1, y=2, cin=1 -> k+4
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        in_valid = 1'b1; mode = ADD; cin = 1'b1; x = 8'(k + 1); y = 8'd2;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k > 0) chk("s1_b2b", 32'({c_out_valid, c_sm}), 32'h200 + 32'(k + 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
